// File: rtl/banco_registros_pkg.sv
// banco_registros_pkg: default sizes and shared typedefs for the register file with scoreboard
package banco_registros_pkg;
   localparam int DATA_W_DEF   = 32;
   localparam int NUM_REGS_DEF = 32;
   localparam int NUM_RD_DEF   = 2;
   localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
   typedef logic [DATA_W_DEF-1:0] reg_data_t;
endpackage

// File: rtl/banco_registros_sb_if.sv
// banco_registros_sb_if: read, write-back, issue and flush signals of the register file
interface banco_registros_sb_if
   import banco_registros_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]             rd_busy;
   logic                          wr_en;
   logic [ADDR_W-1:0]             wr_addr;
   logic [DATA_W-1:0]             wr_data;
   logic                          issue_en;
   logic [ADDR_W-1:0]             issue_addr;
   logic                          flush;
   logic                          any_busy;
   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      input  rd_data, rd_busy, any_busy
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr, flush,
      output rd_data, rd_busy, any_busy
   );
endinterface

// File: rtl/banco_registros_sb_scoreboard.sv
// reg_scoreboard: one pending bit per register; flush beats issue, issue beats write-back
module reg_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy,
   output logic                any_busy
);
   localparam logic [NUM_REGS-1:0] ONE = 1;
   logic [NUM_REGS-1:0] set_v, clr_v, busy_n;
   always_comb begin
      clr_v  = (wr_en && wr_addr != '0) ? ONE << wr_addr : '0;
      set_v  = (issue_en && issue_addr != '0) ? ONE << issue_addr : '0;
      busy_n = flush ? '0 : (busy & ~clr_v) | set_v;
   end
   always_ff @(posedge CLK)
      busy <= RESET ? '0 : busy_n;
   assign any_busy = |busy;
endmodule

// File: rtl/banco_registros_sb.sv
// banco_registros_sb: register file with issue scoreboard; define BANCO_REGISTROS_BYPASS_EN for write-through forwarding
module banco_registros_sb
   import banco_registros_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int NUM_RD   = NUM_RD_DEF
) (
   input logic CLK,
   input logic RESET,
   banco_registros_sb_if.slave bus
);
   localparam int ADDR_W = $clog2(NUM_REGS);
`ifdef BANCO_REGISTROS_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_RD-1:0]   fwd;
   logic                wr_ok;
   assign wr_ok = bus.wr_en && bus.wr_addr != '0;
   reg_scoreboard #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_sb (
      .CLK        (CLK),
      .RESET      (RESET),
      .issue_en   (bus.issue_en),
      .issue_addr (bus.issue_addr),
      .wr_en      (bus.wr_en),
      .wr_addr    (bus.wr_addr),
      .flush      (bus.flush),
      .busy       (busy),
      .any_busy   (bus.any_busy)
   );
   always_ff @(posedge CLK)
      if (RESET)
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      else if (wr_ok)
         regs[bus.wr_addr] <= bus.wr_data;
   always_comb begin
      fwd = '0;
      for (int p = 0; p < NUM_RD; p++)
         fwd[p] = BYPASS && wr_ok && bus.wr_addr == bus.rd_addr[p];
   end
   // register 0 is masked on read so it stays 0 even if the array is uninitialised
   always_ff @(posedge CLK)
      for (int p = 0; p < NUM_RD; p++) begin
         bus.rd_data[p] <= RESET ? '0 : fwd[p] ? bus.wr_data :
                           bus.rd_addr[p] == '0 ? '0 : regs[bus.rd_addr[p]];
         bus.rd_busy[p] <= RESET ? 1'b0 : !fwd[p] && busy[bus.rd_addr[p]];
      end
endmodule
